// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_SYS,
    REL_CPU,
    REL_IO,
    RUN,
    SW_HOLD
  } seq_state_e;

  localparam int RETRY_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the local clock.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// PLL reset / lock qualification and ordered SYS -> CPU -> IO reset release,
// with lock-loss re-sequencing and a software reset of the CPU and IO domains.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 2400,
  parameter int STABLE_CYCLES  = 240,
  parameter int STAGE_GAP      = 16,
  parameter int CNT_W          = 16
) (
  input  logic               clk24_ref,
  input  logic               rst,
  input  logic               locked,
  input  logic               sw_rst_req,
  output logic               pll_rst,
  output logic               rst_sys,
  output logic               rst_cpu,
  output logic               rst_io,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  logic locked_s;
  logic req_s;

  sync_2ff u_sync_locked (
    .clk (clk24_ref),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  sync_2ff u_sync_req (
    .clk (clk24_ref),
    .rst (rst),
    .d   (sw_rst_req),
    .q   (req_s)
  );

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_prev_q, req_prev_d;
  logic               pll_rst_q, pll_rst_d;
  logic               rst_sys_q, rst_sys_d;
  logic               rst_cpu_q, rst_cpu_d;
  logic               rst_io_q, rst_io_d;
  logic               ready_q, ready_d;
  logic               lock_lost_q, lock_lost_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               sw_edge;
  logic               released;

  assign sw_edge  = req_s & ~req_prev_q;
  assign released = state_q inside {REL_SYS, REL_CPU, REL_IO, RUN, SW_HOLD};

  always_comb begin
    state_d     = state_q;
    lock_lost_d = lock_lost_q;
    retry_d     = retry_q;
    req_prev_d  = req_s;

    // Lock loss once any domain is out of reset outranks everything else.
    if (released && !locked_s) begin
      state_d     = PLL_RST;
      lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = PLL_RST;
            if (retry_q != {RETRY_W{1'b1}}) retry_d = retry_q + RETRY_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s)                  state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_d = REL_SYS;
        end
        REL_SYS: begin
          if (cnt_q == GAP_LAST) state_d = REL_CPU;
        end
        REL_CPU: begin
          if (cnt_q == GAP_LAST) state_d = REL_IO;
        end
        REL_IO: begin
          if (cnt_q == GAP_LAST) state_d = RUN;
        end
        RUN: begin
          if (sw_edge) state_d = SW_HOLD;
        end
        SW_HOLD: begin
          if (cnt_q == GAP_LAST) state_d = REL_CPU;
        end
        default: state_d = PLL_RST;
      endcase
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    // Outputs follow the next state so they settle one cycle after the decision.
    pll_rst_d = (state_d == PLL_RST);
    rst_sys_d = state_d inside {PLL_RST, WAIT_LOCK, STABLE};
    rst_cpu_d = rst_sys_d | (state_d inside {REL_SYS, SW_HOLD});
    rst_io_d  = rst_cpu_d | (state_d == REL_CPU);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk24_ref) begin
    if (rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      req_prev_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      rst_sys_q   <= 1'b1;
      rst_cpu_q   <= 1'b1;
      rst_io_q    <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_prev_q  <= req_prev_d;
      pll_rst_q   <= pll_rst_d;
      rst_sys_q   <= rst_sys_d;
      rst_cpu_q   <= rst_cpu_d;
      rst_io_q    <= rst_io_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_sys   = rst_sys_q;
  assign rst_cpu   = rst_cpu_q;
  assign rst_io    = rst_io_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed and randomized bench for rst_sequencer against a phase/deadline reference model.
module tb_rst_sequencer;

  localparam int PLL_N  = 4;
  localparam int TO_N   = 64;
  localparam int STAB_N = 8;
  localparam int GAP_N  = 4;

  localparam int P_PLL  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_SYS  = 3;
  localparam int P_CPU  = 4;
  localparam int P_IO   = 5;
  localparam int P_RUN  = 6;
  localparam int P_SWH  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       pll_rst, rst_sys, rst_cpu, rst_io, ready, lock_lost;
  logic [7:0] retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: current phase, absolute cycle it was entered, and the
  // input history as seen through the two-cycle synchronisers.
  int   m_phase = P_PLL;
  int   m_entered = 0;
  int   m_retries = 0;
  logic m_lost = 1'b0;
  logic lk_d1 = 1'b0, lk_d2 = 1'b0;
  logic rq_d1 = 1'b0, rq_d2 = 1'b0, rq_d3 = 1'b0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .PLL_RST_CYCLES (PLL_N),
    .LOCK_TIMEOUT   (TO_N),
    .STABLE_CYCLES  (STAB_N),
    .STAGE_GAP      (GAP_N),
    .CNT_W          (16)
  ) dut (
    .clk24_ref  (clk),
    .rst        (rst),
    .locked     (locked),
    .sw_rst_req (sw_rst_req),
    .pll_rst    (pll_rst),
    .rst_sys    (rst_sys),
    .rst_cpu    (rst_cpu),
    .rst_io     (rst_io),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Number of domains out of reset in each phase.
  function automatic int domains_up(input int ph);
    case (ph)
      P_SYS, P_SWH: return 1;
      P_CPU:        return 2;
      P_IO, P_RUN:  return 3;
      default:      return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic lk, input logic rq);
    logic ls;
    logic sw_rise;
    int   el;
    int   nxt;
    if (r) begin
      m_phase = P_PLL; m_entered = cyc; m_retries = 0; m_lost = 1'b0;
      lk_d1 = 1'b0; lk_d2 = 1'b0; rq_d1 = 1'b0; rq_d2 = 1'b0; rq_d3 = 1'b0;
      return;
    end
    ls      = lk_d2;
    sw_rise = rq_d2 && !rq_d3;
    rq_d3 = rq_d2; rq_d2 = rq_d1; rq_d1 = rq;
    lk_d2 = lk_d1; lk_d1 = lk;
    el  = cyc - m_entered;
    nxt = m_phase;
    if (m_phase == P_PLL) begin
      if (el == PLL_N) nxt = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (ls) nxt = P_STAB;
      else if (el == TO_N) begin
        nxt = P_PLL;
        if (m_retries < 255) m_retries++;
      end
    end else if (m_phase == P_STAB) begin
      if (!ls) nxt = P_WAIT;
      else if (el == STAB_N) nxt = P_SYS;
    end else if (!ls) begin
      nxt = P_PLL;
      m_lost = 1'b1;
    end else if (m_phase == P_RUN) begin
      if (sw_rise) nxt = P_SWH;
    end else if (el == GAP_N) begin
      case (m_phase)
        P_SYS:   nxt = P_CPU;
        P_CPU:   nxt = P_IO;
        P_IO:    nxt = P_RUN;
        default: nxt = P_CPU;
      endcase
    end
    if (nxt != m_phase) begin
      m_phase   = nxt;
      m_entered = cyc;
    end
  endtask

  task automatic tick();
    logic r, l, q;
    int   up;
    r = rst; l = locked; q = sw_rst_req;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, l, q);
    up = domains_up(m_phase);
    chk("pll_rst",   32'(pll_rst),   32'(m_phase == P_PLL));
    chk("rst_sys",   32'(rst_sys),   32'(up < 1));
    chk("rst_cpu",   32'(rst_cpu),   32'(up < 2));
    chk("rst_io",    32'(rst_io),    32'(up < 3));
    chk("ready",     32'(ready),     32'(m_phase == P_RUN));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retries));
    chk("order",     32'((rst_sys <= rst_cpu) && (rst_cpu <= rst_io)), 32'(1));
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(ready), 32'(1));
  endtask

  initial begin
    int   t_sys, t_cpu, t_io, t_rise, hi, rises, bad, hold, n, low_left;
    logic prev;

    // 1. Cold start
    rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0;
    repeat (3) tick();
    chk("reset_pll_rst", 32'(pll_rst), 32'(1));
    chk("reset_rst_io", 32'(rst_io), 32'(1));
    chk("reset_ready", 32'(ready), 32'(0));
    rst = 1'b0;
    hi = pll_rst ? 1 : 0;
    t_sys = -1; t_cpu = -1; t_io = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 11) locked = 1'b1;
      tick();
      if (pll_rst) hi++;
      if (t_sys < 0 && rst_sys === 1'b0) t_sys = i;
      if (t_cpu < 0 && rst_cpu === 1'b0) t_cpu = i;
      if (t_io < 0 && rst_io === 1'b0) t_io = i;
    end
    chk("cold_pll_high", 32'(hi), 32'(PLL_N));
    chk("cold_sys_fall", 32'(t_sys), 32'(10 + 3 + STAB_N));
    chk("cold_cpu_gap", 32'(t_cpu - t_sys), 32'(GAP_N));
    chk("cold_io_gap", 32'(t_io - t_cpu), 32'(GAP_N));
    chk("cold_ready", 32'(ready), 32'(1));
    chk("cold_retry", 32'(retry_cnt), 32'(0));

    // 2. No lock for 300 cycles
    rst = 1'b1; locked = 1'b0;
    tick();
    rst = 1'b0;
    hi = pll_rst ? 1 : 0; rises = 0; prev = pll_rst; bad = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (pll_rst) hi++;
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
      if (!(rst_sys && rst_cpu && rst_io)) bad++;
    end
    chk("nolock_pll_high", 32'(hi), 32'(PLL_N * (1 + 300 / (PLL_N + TO_N))));
    chk("nolock_repulses", 32'(rises), 32'(300 / (PLL_N + TO_N)));
    chk("nolock_retry", 32'(retry_cnt), 32'(4));
    chk("nolock_rst_held", 32'(bad), 32'(0));

    // 3. Glitchy lock
    rst = 1'b1; locked = 1'b0;
    tick();
    rst = 1'b0;
    repeat ($urandom_range(0, 30)) tick();
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    t_rise = cyc + 1;
    n = 0;
    while (rst_sys !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk("glitch_sys_fall", 32'(cyc), 32'(t_rise + 2 + STAB_N));
    chk("glitch_lock_lost", 32'(lock_lost), 32'(0));
    wait_ready("glitch_ready", 100);

    // 4. Lock loss in RUN
    repeat ($urandom_range(0, 10)) tick();
    locked = 1'b0;
    repeat (3) tick();
    chk("loss_rst_sys", 32'(rst_sys), 32'(1));
    chk("loss_rst_io", 32'(rst_io), 32'(1));
    chk("loss_ready", 32'(ready), 32'(0));
    chk("loss_flag", 32'(lock_lost), 32'(1));
    locked = 1'b1;
    wait_ready("loss_reseq_ready", 200);
    chk("loss_sticky", 32'(lock_lost), 32'(1));

    // 5. Software reset
    repeat ($urandom_range(0, 10)) tick();
    sw_rst_req = 1'b1;
    hold = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rst_cpu && rst_io && !rst_sys) hold++;
      if (rst_sys) bad++;
    end
    chk("sw_hold_len", 32'(hold), 32'(GAP_N));
    chk("sw_sys_kept", 32'(bad), 32'(0));
    wait_ready("sw_ready", 60);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!ready) bad++;
    end
    chk("sw_level_no_retrigger", 32'(bad), 32'(0));
    sw_rst_req = 1'b0;
    repeat (3) tick();

    // 6. Collision then reset mid REL_CPU
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("coll_ready", 100);
    chk("coll_lost_cleared", 32'(lock_lost), 32'(0));
    locked = 1'b0; sw_rst_req = 1'b1;
    repeat (3) tick();
    chk("coll_pll_path", 32'(pll_rst), 32'(1));
    chk("coll_rst_sys", 32'(rst_sys), 32'(1));
    chk("coll_lost", 32'(lock_lost), 32'(1));
    locked = 1'b1; sw_rst_req = 1'b0;
    n = 0;
    while (!(rst_sys === 1'b0 && rst_cpu === 1'b0 && rst_io === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    chk("coll_reach_rel_cpu", 32'(rst_io && !rst_cpu), 32'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pll", 32'(pll_rst), 32'(1));
    chk("midrst_sys", 32'(rst_sys), 32'(1));
    chk("midrst_cpu", 32'(rst_cpu), 32'(1));
    chk("midrst_lost", 32'(lock_lost), 32'(0));

    // 7. Randomized soak against the model
    low_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (low_left > 0) begin
        low_left--;
        locked = (low_left == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        locked = 1'b0;
        low_left = $urandom_range(1, 100);
      end
      if ($urandom_range(0, 29) == 0) sw_rst_req = ~sw_rst_req;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
